// File: rtl/semaforo_monitor.sv
// Checks the Semaforo lamp outputs. It decodes the phase, times each phase and enforces the G->Y->R order and durations.
// One-cycle latency: all outputs reflect the lamp sample taken on the same edge. There is no backpressure.
module semaforo_monitor #(
  parameter int G_TICKS = 300,
  parameter int Y_TICKS = 50,
  parameter int R_TICKS = 200,
  parameter int TOL     = 2,
  parameter int CNT_W   = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             green,
  input  logic             yellow,
  input  logic             red,
  input  logic             clear_fault,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] dur_out,
  output logic             dur_valid,
  output logic [7:0]       cycle_count,
  output logic             fault,
  output logic [2:0]       fault_code
);

  typedef enum logic [2:0] {SYNC, TRK_G, TRK_Y, TRK_R, FAULT} state_t;

  localparam logic [1:0] PH_R    = 2'b00;
  localparam logic [1:0] PH_Y    = 2'b01;
  localparam logic [1:0] PH_G    = 2'b10;
  localparam logic [1:0] PH_NONE = 2'b11;

  localparam logic [CNT_W-1:0] G_MIN  = CNT_W'(G_TICKS - TOL);
  localparam logic [CNT_W-1:0] Y_MIN  = CNT_W'(Y_TICKS - TOL);
  localparam logic [CNT_W-1:0] R_MIN  = CNT_W'(R_TICKS - TOL);
  localparam logic [CNT_W-1:0] G_TRIP = CNT_W'(G_TICKS + TOL + 1);
  localparam logic [CNT_W-1:0] Y_TRIP = CNT_W'(Y_TICKS + TOL + 1);
  localparam logic [CNT_W-1:0] R_TRIP = CNT_W'(R_TICKS + TOL + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] dur_out_n, nom_min, nom_trip;
  logic             dur_valid_n;
  logic [7:0]       cycle_count_n;
  logic [2:0]       fault_code_n;
  logic [1:0]       lamp_cnt, dec_ph, succ_ph;
  logic             multi, dark, change;

  assign lamp_cnt = {1'b0, green} + {1'b0, yellow} + {1'b0, red};
  assign multi    = (lamp_cnt > 2'd1);
  assign dark     = (lamp_cnt == 2'd0);
  assign dec_ph   = (multi || dark) ? PH_NONE : (green ? PH_G : (yellow ? PH_Y : PH_R));
  // A change needs a valid phase on both sides; leaving reset or a dark/multi sample is not one.
  assign change   = (phase != PH_NONE) && (dec_ph != PH_NONE) && (dec_ph != phase);
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

  assign locked = (state == TRK_G) || (state == TRK_Y) || (state == TRK_R);
  assign fault  = (state == FAULT);

  always_comb begin
    state_n       = state;
    cnt_n         = (dec_ph == phase) ? cnt_inc : CNT_W'(1);
    dur_out_n     = dur_out;
    dur_valid_n   = 1'b0;
    cycle_count_n = cycle_count;
    fault_code_n  = fault_code;
    nom_min       = R_MIN;
    nom_trip      = R_TRIP;
    succ_ph       = PH_G;

    case (state)
      TRK_G: begin nom_min = G_MIN; nom_trip = G_TRIP; succ_ph = PH_Y; end
      TRK_Y: begin nom_min = Y_MIN; nom_trip = Y_TRIP; succ_ph = PH_R; end
      default: ;
    endcase

    if (state == FAULT) begin
      if (clear_fault) begin
        state_n      = SYNC;
        fault_code_n = 3'd0;
        cnt_n        = '0;
      end
    end else if (multi) begin
      state_n      = FAULT;
      fault_code_n = 3'd1;
    end else if (dark) begin
      state_n      = FAULT;
      fault_code_n = 3'd2;
    end else if (state == SYNC) begin
      if (change) begin
        state_n = (dec_ph == PH_G) ? TRK_G : ((dec_ph == PH_Y) ? TRK_Y : TRK_R);
      end
    end else if (change) begin
      dur_out_n   = cnt;
      dur_valid_n = 1'b1;
      if (dec_ph != succ_ph) begin
        state_n      = FAULT;
        fault_code_n = 3'd3;
      end else if (cnt < nom_min) begin
        state_n      = FAULT;
        fault_code_n = 3'd4;
      end else begin
        state_n = (dec_ph == PH_G) ? TRK_G : ((dec_ph == PH_Y) ? TRK_Y : TRK_R);
        if (state == TRK_R) cycle_count_n = cycle_count + 8'd1;
      end
    end else if (cnt_inc >= nom_trip) begin
      // Lamp held too long: flag it on the edge the limit is crossed, not at the eventual change.
      state_n      = FAULT;
      fault_code_n = 3'd5;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      cnt         <= '0;
      phase       <= PH_NONE;
      dur_out     <= '0;
      dur_valid   <= 1'b0;
      cycle_count <= 8'd0;
      fault_code  <= 3'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      phase       <= dec_ph;
      dur_out     <= dur_out_n;
      dur_valid   <= dur_valid_n;
      cycle_count <= cycle_count_n;
      fault_code  <= fault_code_n;
    end
  end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios plus randomized lamp traffic.
// The lamp traffic is checked against a phase-run reference model.
module tb_semaforo_monitor;
  localparam int CW = 9;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          green = 1'b0, yellow = 1'b0, red = 1'b0, clear_fault = 1'b0;
  logic [1:0]    phase;
  logic          locked, dur_valid, fault;
  logic [CW-1:0] dur_out;
  logic [7:0]    cycle_count;
  logic [2:0]    fault_code;

  semaforo_monitor dut (
    .clock(clock), .reset_n(reset_n), .green(green), .yellow(yellow), .red(red),
    .clear_fault(clear_fault), .phase(phase), .locked(locked), .dur_out(dur_out),
    .dur_valid(dur_valid), .cycle_count(cycle_count), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, edge_mis = 0, fault_seen = 0;
  int nom [3] = '{200, 50, 300};   // indexed by phase: R=0, Y=1, G=2
  int nomseq [3] = '{300, 50, 200};
  // Reference model: mode 0 = waiting for first change, 1 = tracking, 2 = faulted
  int m_mode, m_ph, m_run, m_cyc, m_code, m_dur;
  bit m_dv;
  int got_q[$], exp_q[$];

  function automatic void model_reset();
    m_mode = 0; m_ph = 3; m_run = 0; m_cyc = 0; m_code = 0; m_dur = 0; m_dv = 0;
  endfunction

  function automatic void model_step(input bit g, input bit y, input bit r, input bit clr);
    int n, np;
    bit chg, cleared;
    n = int'(g) + int'(y) + int'(r);
    np = (n != 1) ? 3 : (g ? 2 : (y ? 1 : 0));
    chg = (m_ph != 3) && (np != 3) && (np != m_ph);
    m_dv = 0;
    cleared = 0;
    if (m_mode == 2) begin
      if (clr) begin m_mode = 0; m_code = 0; cleared = 1; end
    end else if (n > 1) begin
      m_mode = 2; m_code = 1;
    end else if (n == 0) begin
      m_mode = 2; m_code = 2;
    end else if (m_mode == 0) begin
      if (chg) m_mode = 1;
    end else if (chg) begin
      m_dur = m_run; m_dv = 1;
      if (np != (m_ph + 2) % 3) begin m_mode = 2; m_code = 3; end
      else if (m_run < nom[m_ph] - 2) begin m_mode = 2; m_code = 4; end
      else if (m_ph == 0) m_cyc = (m_cyc + 1) % 256;
    end else if (m_run + 1 >= nom[m_ph] + 3) begin
      m_mode = 2; m_code = 5;
    end
    if (cleared) m_run = 0;
    else m_run = (np == m_ph) ? ((m_run < 511) ? m_run + 1 : 511) : 1;
    m_ph = np;
  endfunction

  task automatic tick(input bit g, input bit y, input bit r, input bit clr);
    green = g; yellow = y; red = r; clear_fault = clr;
    @(posedge clock);
    model_step(g, y, r, clr);
    #1;
    if (dur_valid === 1'b1) got_q.push_back(int'(dur_out));
    if (m_dv) exp_q.push_back(m_dur);
    if (fault === 1'b1) fault_seen++;
    if (phase !== 2'(m_ph) || locked !== (m_mode == 1) || fault !== (m_mode == 2) ||
        fault_code !== 3'(m_code) || dur_valid !== m_dv || dur_out !== CW'(m_dur) ||
        cycle_count !== 8'(m_cyc))
      edge_mis++;
  endtask

  task automatic hold(input int ph, input int n);
    for (int i = 0; i < n; i++) tick(ph == 2, ph == 1, ph == 0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    edge_mis = 0; fault_seen = 0;
    got_q.delete(); exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++;
    if (phase !== 2'b11) begin bad++; $display("FAIL reset_phase got=%b want=11", phase); end
    total++;
    if ({locked, dur_out, dur_valid, cycle_count, fault, fault_code} !== '0) begin
      bad++; $display("FAIL reset_zero got=%b/%0d/%b/%0d/%b/%0d want=all zero",
                      locked, dur_out, dur_valid, cycle_count, fault, fault_code);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    hold(0, 37);
    for (int c = 0; c < 3; c++) begin
      hold(2, 300);
      if (c == 2) begin
        total++;
        if (cycle_count !== 8'd2) begin bad++; $display("FAIL nominal_count2 got=%0d want=2", cycle_count); end
      end
      hold(1, 50);
      hold(0, 200);
    end
    hold(2, 5);
    total++;
    if (cycle_count !== 8'd3) begin bad++; $display("FAIL nominal_count3 got=%0d want=3", cycle_count); end
    total++;
    if (got_q.size() != 9) begin
      bad++; $display("FAIL nominal_pulses got=%0d want=9", got_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        total++;
        if (got_q[i] != nomseq[i % 3]) begin
          bad++; $display("FAIL nominal_dur[%0d] got=%0d want=%0d", i, got_q[i], nomseq[i % 3]);
        end
      end
    end
    total++;
    if (fault_seen != 0) begin bad++; $display("FAIL nominal_nofault fault_edges=%0d want=0", fault_seen); end
    total++;
    if (edge_mis != 0) begin bad++; $display("FAIL nominal_model mismatched_edges=%0d want=0", edge_mis); end
  endtask

  task automatic test_tolerance();
    do_reset();
    hold(0, 5);
    hold(2, 300); hold(1, 48); hold(0, 200);
    hold(2, 300); hold(1, 52); hold(0, 200);
    hold(2, 300);
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL tol_48_52 fault=%b code=%0d want=0", fault, fault_code); end
    hold(1, 47); hold(0, 1);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      bad++; $display("FAIL tol_47_code fault=%b code=%0d want=1/4", fault, fault_code);
    end
    total++;
    if (dur_valid !== 1'b1 || dur_out !== 9'd47) begin
      bad++; $display("FAIL tol_47_dur valid=%b dur=%0d want=1/47", dur_valid, dur_out);
    end
    total++;
    if (edge_mis != 0) begin bad++; $display("FAIL tol_model mismatched_edges=%0d want=0", edge_mis); end
  endtask

  task automatic test_stuck();
    do_reset();
    hold(0, 5);
    hold(2, 302);
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL stuck_302 fault=%b want=0", fault); end
    hold(2, 1);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd5 || dur_valid !== 1'b0) begin
      bad++; $display("FAIL stuck_303 fault=%b code=%0d valid=%b want=1/5/0", fault, fault_code, dur_valid);
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL stuck_pulses got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_order();
    do_reset();
    hold(0, 5); hold(2, 300); hold(0, 1);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      bad++; $display("FAIL order_code fault=%b code=%0d want=1/3", fault, fault_code);
    end
    total++;
    if (dur_valid !== 1'b1 || dur_out !== 9'd300) begin
      bad++; $display("FAIL order_dur valid=%b dur=%0d want=1/300", dur_valid, dur_out);
    end
  endtask

  task automatic test_multi_clear();
    do_reset();
    hold(0, 5); hold(2, 300); hold(1, 50);
    tick(1, 0, 1, 0);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd1) begin
      bad++; $display("FAIL multi_code fault=%b code=%0d want=1/1", fault, fault_code);
    end
    hold(0, 20); hold(2, 20); tick(0, 0, 0, 0); hold(2, 10);
    total++;
    if (fault_code !== 3'd1 || phase !== 2'b10) begin
      bad++; $display("FAIL multi_sticky code=%0d phase=%b want=1/10", fault_code, phase);
    end
    tick(0, 1, 0, 1);
    total++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL clear fault=%b code=%0d locked=%b want=0/0/0", fault, fault_code, locked);
    end
    hold(1, 10);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL clear_partial locked=%b want=0", locked); end
    hold(0, 1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL clear_relock locked=%b want=1", locked); end
    tick(0, 0, 0, 0);
    total++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      bad++; $display("FAIL dark_code fault=%b code=%0d want=1/2", fault, fault_code);
    end
    total++;
    if (edge_mis != 0) begin bad++; $display("FAIL multi_model mismatched_edges=%0d want=0", edge_mis); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(0, 5); hold(2, 300); hold(1, 50); hold(0, 200); hold(2, 300); hold(1, 20);
    total++;
    if (cycle_count !== 8'd1) begin bad++; $display("FAIL mid_precount got=%0d want=1", cycle_count); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (phase !== 2'b11 || {locked, dur_out, dur_valid, cycle_count, fault, fault_code} !== '0) begin
      bad++; $display("FAIL mid_async phase=%b locked=%b dur=%0d count=%0d want=11/0/0/0",
                      phase, locked, dur_out, cycle_count);
    end
    do_reset();
    hold(1, 10);
    total++;
    if (locked !== 1'b0 || cycle_count !== 8'd0) begin
      bad++; $display("FAIL mid_resume locked=%b count=%0d want=0/0", locked, cycle_count);
    end
    hold(0, 1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock locked=%b want=1", locked); end
  endtask

  task automatic test_random();
    int cur, nxt, len, diff;
    do_reset();
    cur = 0;
    hold(cur, 1 + $urandom_range(0, 20));
    for (int k = 0; k < 45; k++) begin
      nxt = (cur + 2) % 3;
      if ($urandom_range(0, 11) == 0) nxt = $urandom_range(0, 2);
      len = nom[nxt] + $urandom_range(0, 6) - 3;
      hold(nxt, len);
      cur = nxt;
      case ($urandom_range(0, 15))
        0: tick(1, 1, 0, 0);
        1: tick(0, 0, 0, 0);
        default: ;
      endcase
      if (m_mode == 2 && $urandom_range(0, 1) == 1) tick(cur == 2, cur == 1, cur == 0, 1'b1);
    end
    total++;
    if (edge_mis != 0) begin bad++; $display("FAIL random_model mismatched_edges=%0d want=0", edge_mis); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_pulses got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      diff = 0;
      foreach (got_q[i]) if (got_q[i] != exp_q[i]) diff++;
      total++;
      if (diff != 0) begin bad++; $display("FAIL random_durs differing=%0d want=0", diff); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_tolerance();
    test_stuck();
    test_order();
    test_multi_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
